pulse_generator: RTL and testbench

Synchronous, programmable periodic pulse source for digital-neuron and stimulus paths. It produces a single-bit pulse train whose period and high-time are set in clock cycles. At the default 100 ps timebase, the defaults give a 200 ps-wide pulse every 400 ps. It supports run-time reconfiguration at period boundaries, polarity inversion and finite bursts.

---
 rtl/pulse_gen_pkg.sv | 26 ++
 rtl/pulse_gen_cfg.sv | 77 +++++++
 rtl/pulse_generator.sv | 139 +++++++++++++
 tb/tb_pulse_generator.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_gen_pkg.sv
// Shared types and defaults for the programmable pulse generator.
package pulse_gen_pkg;

    localparam int unsigned PG_CNT_W      = 16;
    localparam int unsigned PG_DEF_PERIOD = 4;
    localparam int unsigned PG_DEF_WIDTH  = 2;

    typedef struct packed {
        logic [PG_CNT_W-1:0] period;
        logic [PG_CNT_W-1:0] width;
        logic                invert;
        logic [PG_CNT_W-1:0] burst;
    } pg_cfg_t;

    // Power-on configuration: given period/width, non-inverted, continuous.
    function automatic pg_cfg_t pg_default(input int unsigned period,
                                           input int unsigned width);
        pg_cfg_t c;
        c.period = PG_CNT_W'(period);
        c.width  = PG_CNT_W'(width);
        c.invert = 1'b0;
        c.burst  = '0;
        return c;
    endfunction

endpackage

// File: rtl/pulse_gen_cfg.sv
// Shadow/pending configuration registers with load validation.
// cfg_c is the configuration the counters run with from this edge onward.
module pulse_gen_cfg
    import pulse_gen_pkg::*;
#(
    parameter int unsigned DEF_PERIOD = PG_DEF_PERIOD,
    parameter int unsigned DEF_WIDTH  = PG_DEF_WIDTH
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    load,
    input  pg_cfg_t load_cfg,
    input  logic    busy,
    input  logic    wrap,
    output pg_cfg_t cfg_c,
    output logic    cfg_err
);

    pg_cfg_t cfg_a;
    pg_cfg_t pend;
    logic    pend_v;

    pg_cfg_t pend_nxt;
    logic    pend_v_nxt;
    logic    err_nxt;
    logic    valid_c;

    assign valid_c = load && (load_cfg.period != '0);

    // Idle loads apply immediately; busy loads wait for the next wrap.
    always_comb begin
        cfg_c      = cfg_a;
        pend_nxt   = pend;
        pend_v_nxt = pend_v;
        err_nxt    = cfg_err;

        if (load && !valid_c) begin
            err_nxt = 1'b1;
        end else if (valid_c) begin
            err_nxt = 1'b0;
        end

        if (!busy) begin
            if (valid_c) begin
                cfg_c = load_cfg;
            end else if (pend_v) begin
                cfg_c = pend;
            end
            pend_v_nxt = 1'b0;
        end else begin
            if (wrap && pend_v) begin
                cfg_c      = pend;
                pend_v_nxt = 1'b0;
            end
            // A load on the wrap edge itself is queued for the following wrap.
            if (valid_c) begin
                pend_nxt   = load_cfg;
                pend_v_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_a   <= pg_default(DEF_PERIOD, DEF_WIDTH);
            pend    <= pg_default(DEF_PERIOD, DEF_WIDTH);
            pend_v  <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_a   <= cfg_c;
            pend    <= pend_nxt;
            pend_v  <= pend_v_nxt;
            cfg_err <= err_nxt;
        end
    end

endmodule

// File: rtl/pulse_generator.sv
// Programmable periodic pulse source: phase/burst counters and registered outputs.
// End-of-period and last-period flags are precomputed one edge ahead.
module pulse_generator
    import pulse_gen_pkg::*;
#(
    parameter int unsigned CNT_W      = PG_CNT_W,
    parameter int unsigned DEF_PERIOD = PG_DEF_PERIOD,
    parameter int unsigned DEF_WIDTH  = PG_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_load,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic             cfg_invert,
    input  logic [CNT_W-1:0] cfg_burst,
    output logic             pulse_out,
    output logic             period_start,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    pg_cfg_t load_cfg;
    pg_cfg_t cfg_c;

    logic [CNT_W-1:0] ph;
    logic [CNT_W-1:0] pcnt;
    logic             at_end;
    logic             last_per;
    logic             need_low;

    logic [CNT_W-1:0] ph_nxt;
    logic [CNT_W-1:0] pcnt_nxt;
    logic             busy_nxt;
    logic             need_low_nxt;
    logic             ps_nxt;
    logic             done_nxt;
    logic             pulse_nxt;
    logic             at_end_nxt;
    logic             last_nxt;

    logic             wrap_c;
    logic             last_c;
    logic             start_c;

    always_comb begin
        load_cfg.period = PG_CNT_W'(cfg_period);
        load_cfg.width  = PG_CNT_W'(cfg_width);
        load_cfg.invert = cfg_invert;
        load_cfg.burst  = PG_CNT_W'(cfg_burst);
    end

    pulse_gen_cfg #(
        .DEF_PERIOD (DEF_PERIOD),
        .DEF_WIDTH  (DEF_WIDTH)
    ) u_cfg (
        .clk      (clk),
        .rst      (rst),
        .load     (cfg_load),
        .load_cfg (load_cfg),
        .busy     (busy),
        .wrap     (wrap_c),
        .cfg_c    (cfg_c),
        .cfg_err  (cfg_err)
    );

    assign wrap_c  = busy && en && at_end;
    assign last_c  = wrap_c && last_per;
    assign start_c = en && !busy && !need_low;

    // Run control: stop on en low, start, burst end, wrap, or advance phase.
    always_comb begin
        ph_nxt       = ph;
        pcnt_nxt     = pcnt;
        busy_nxt     = busy;
        need_low_nxt = need_low;
        ps_nxt       = 1'b0;
        done_nxt     = 1'b0;

        if (!en) begin
            busy_nxt     = 1'b0;
            ph_nxt       = '0;
            pcnt_nxt     = '0;
            need_low_nxt = 1'b0;
        end else if (start_c) begin
            busy_nxt = 1'b1;
            ph_nxt   = '0;
            pcnt_nxt = '0;
            ps_nxt   = 1'b1;
        end else if (busy) begin
            if (last_c) begin
                busy_nxt     = 1'b0;
                ph_nxt       = '0;
                pcnt_nxt     = '0;
                done_nxt     = 1'b1;
                need_low_nxt = 1'b1;
            end else if (wrap_c) begin
                ph_nxt   = '0;
                pcnt_nxt = pcnt + CNT_W'(1);
                ps_nxt   = 1'b1;
            end else begin
                ph_nxt = ph + CNT_W'(1);
            end
        end

        pulse_nxt  = busy_nxt ? ((ph_nxt < CNT_W'(cfg_c.width)) ^ cfg_c.invert)
                              : cfg_c.invert;
        at_end_nxt = (ph_nxt >= (CNT_W'(cfg_c.period) - CNT_W'(1)));
        last_nxt   = (cfg_c.burst != '0) &&
                     (pcnt_nxt >= (CNT_W'(cfg_c.burst) - CNT_W'(1)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ph           <= '0;
            pcnt         <= '0;
            at_end       <= 1'b0;
            last_per     <= 1'b0;
            need_low     <= 1'b0;
            busy         <= 1'b0;
            period_start <= 1'b0;
            done         <= 1'b0;
            pulse_out    <= 1'b0;
        end else begin
            ph           <= ph_nxt;
            pcnt         <= pcnt_nxt;
            at_end       <= at_end_nxt;
            last_per     <= last_nxt;
            need_low     <= need_low_nxt;
            busy         <= busy_nxt;
            period_start <= ps_nxt;
            done         <= done_nxt;
            pulse_out    <= pulse_nxt;
        end
    end

endmodule

// File: tb/tb_pulse_generator.sv
// Directed scoreboard bench for pulse_generator.
module tb_pulse_generator;

    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             cfg_load;
    logic [CNT_W-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_width;
    logic             cfg_invert;
    logic [CNT_W-1:0] cfg_burst;
    logic             pulse_out;
    logic             period_start;
    logic             busy;
    logic             done;
    logic             cfg_err;

    int   checks   = 0;
    int   failures = 0;
    logic exp_err;

    typedef struct packed {
        logic pulse;
        logic ps;
        logic busy;
        logic done;
        logic err;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    always #5 clk = ~clk;

    pulse_generator #(
        .CNT_W      (CNT_W),
        .DEF_PERIOD (4),
        .DEF_WIDTH  (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .cfg_load     (cfg_load),
        .cfg_period   (cfg_period),
        .cfg_width    (cfg_width),
        .cfg_invert   (cfg_invert),
        .cfg_burst    (cfg_burst),
        .pulse_out    (pulse_out),
        .period_start (period_start),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err)
    );

    task automatic check_bit(input string tag, input string sig,
                             input logic got, input logic want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s %s got=%b exp=%b", tag, sig, got, want);
        end
    endtask

    // Push expectation, clock one edge, then pop and compare against the DUT.
    task automatic tick(input logic ep, input logic eps, input logic eb,
                        input logic ed, input string tag);
        exp_t  e;
        string t;
        exp_q.push_back('{ep, eps, eb, ed, exp_err});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check_bit(t, "pulse_out",    pulse_out,    e.pulse);
        check_bit(t, "period_start", period_start, e.ps);
        check_bit(t, "busy",         busy,         e.busy);
        check_bit(t, "done",         done,         e.done);
        check_bit(t, "cfg_err",      cfg_err,      e.err);
    endtask

    task automatic period_chk(input int p, input int w, input logic inv,
                              input string tag);
        for (int c = 0; c < p; c++) begin
            tick(((c < w) ? 1'b1 : 1'b0) ^ inv, (c == 0), 1'b1, 1'b0, tag);
        end
    endtask

    task automatic set_cfg(input int p, input int w, input logic inv, input int b);
        cfg_load   = 1'b1;
        cfg_period = CNT_W'(p);
        cfg_width  = CNT_W'(w);
        cfg_invert = inv;
        cfg_burst  = CNT_W'(b);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        cfg_load   = 1'b0;
        cfg_period = '0;
        cfg_width  = '0;
        cfg_invert = 1'b0;
        cfg_burst  = '0;
        exp_err    = 1'b0;
        #2;
        tick(0, 0, 0, 0, "reset");
        tick(0, 0, 0, 0, "reset");
        rst = 1'b0;

        // Defaults: 1,1,0,0 with period_start every 4 cycles
        en = 1'b1;
        repeat (3) period_chk(4, 2, 1'b0, "dflt");
        en = 1'b0;
        tick(0, 0, 0, 0, "dflt_stop");

        // Idle load, inverted output
        set_cfg(5, 1, 1'b1, 0);
        tick(1, 0, 0, 0, "idle_load");
        en = 1'b1;
        repeat (2) period_chk(5, 1, 1'b1, "inv");
        en = 1'b0;
        tick(1, 0, 0, 0, "inv_stop");

        // Rejected load keeps old config; later valid load clears the error
        set_cfg(0, 3, 1'b0, 0);
        exp_err = 1'b1;
        tick(1, 0, 0, 0, "bad_load");
        en = 1'b1;
        period_chk(5, 1, 1'b1, "after_bad");
        en = 1'b0;
        tick(1, 0, 0, 0, "bad_stop");
        set_cfg(4, 2, 1'b0, 3);
        exp_err = 1'b0;
        tick(0, 0, 0, 0, "good_load");

        // Burst of 3, done strobe, no restart until en toggles
        en = 1'b1;
        repeat (3) period_chk(4, 2, 1'b0, "burst");
        tick(0, 0, 0, 1, "burst_done");
        repeat (3) tick(0, 0, 0, 0, "burst_hold");
        en = 1'b0;
        tick(0, 0, 0, 0, "burst_low");
        en = 1'b1;
        period_chk(4, 2, 1'b0, "burst_rerun");
        en = 1'b0;
        tick(0, 0, 0, 0, "rerun_stop");

        // Mid-run load at phase 1 takes effect at the next wrap
        set_cfg(4, 2, 1'b0, 0);
        tick(0, 0, 0, 0, "cont_load");
        en = 1'b1;
        tick(1, 1, 1, 0, "midrun");
        set_cfg(6, 2, 1'b0, 0);
        tick(1, 0, 1, 0, "midrun");
        tick(0, 0, 1, 0, "midrun");
        tick(0, 0, 1, 0, "midrun");
        repeat (2) period_chk(6, 2, 1'b0, "p6");
        // Load exactly on a wrap edge is deferred one period
        set_cfg(3, 1, 1'b0, 0);
        period_chk(6, 2, 1'b0, "wrap_load");
        repeat (2) period_chk(3, 1, 1'b0, "p3");
        en = 1'b0;
        tick(0, 0, 0, 0, "p3_stop");

        // width 0: constant inactive
        set_cfg(4, 0, 1'b0, 0);
        tick(0, 0, 0, 0, "w0_load");
        en = 1'b1;
        repeat (2) period_chk(4, 0, 1'b0, "w0");
        en = 1'b0;
        tick(0, 0, 0, 0, "w0_stop");

        // width >= period: constant active, then drop en mid-pulse
        set_cfg(4, 7, 1'b0, 0);
        tick(0, 0, 0, 0, "w7_load");
        en = 1'b1;
        repeat (2) period_chk(4, 7, 1'b0, "w7");
        en = 1'b0;
        tick(0, 0, 0, 0, "w7_drop");
        set_cfg(4, 2, 1'b0, 0);
        tick(0, 0, 0, 0, "drop_load");
        en = 1'b1;
        tick(1, 1, 1, 0, "drop_run");
        en = 1'b0;
        tick(0, 0, 0, 0, "drop_stop");

        // Reset mid-run discards pending config and the error flag
        set_cfg(5, 3, 1'b1, 0);
        tick(1, 0, 0, 0, "rst_load");
        en = 1'b1;
        tick(0, 1, 1, 0, "rst_run");
        tick(0, 0, 1, 0, "rst_run");
        set_cfg(7, 1, 1'b0, 0);
        tick(0, 0, 1, 0, "rst_run");
        set_cfg(0, 1, 1'b0, 0);
        exp_err = 1'b1;
        tick(1, 0, 1, 0, "rst_run");
        rst     = 1'b1;
        exp_err = 1'b0;
        tick(0, 0, 0, 0, "rst_mid");
        rst = 1'b0;
        repeat (2) period_chk(4, 2, 1'b0, "rst_dflt");
        en = 1'b0;
        tick(0, 0, 0, 0, "final_stop");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
